nibble_serial_adder: RTL and testbench

Sequential controller that adds two multi-nibble words by stepping them, one nibble per clock, through the team's existing combinational 4-bit ripple adder (ports A, B, ci, S, co). The block sits on both sides of that adder. It latches the operands, drives the adder's inputs, and captures the adder's sum and carry into a result register. It then reports completion with a single-cycle pulse.

---
 rtl/nibble_serial_adder.sv | 119 +++++++++++
 tb/tb_nibble_serial_adder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-nibble adder that walks the operands one nibble per clock through an
// external 4-bit ripple adder. Optional subtract mode is built in with macro ADDSUB_EN.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
`ifdef ADDSUB_EN
  input  logic                   sub,
`endif
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_ci,
  input  logic [3:0]             add_s,
  input  logic                   add_co
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          carry;
  logic [IW-1:0] idx;
`ifdef ADDSUB_EN
  logic          sub_reg;
`endif

  // The adder inputs are only live during RUN so the shared adder sees zeros otherwise.
  always_comb begin
    add_a  = 4'h0;
    add_b  = 4'h0;
    add_ci = 1'b0;
    if (state == RUN) begin
      for (int n = 0; n < NIBBLES; n++) begin
        if (idx == IW'(n)) begin
          add_a = a_reg[4*n +: 4];
          add_b = b_reg[4*n +: 4];
        end
      end
`ifdef ADDSUB_EN
      if (sub_reg) add_b = ~add_b;
`endif
      add_ci = carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      idx   <= '0;
`ifdef ADDSUB_EN
      sub_reg <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_reg <= op_a;
            b_reg <= op_b;
`ifdef ADDSUB_EN
            sub_reg <= sub;
            carry   <= sub ? 1'b1 : cin;
`else
            carry   <= cin;
`endif
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          for (int n = 0; n < NIBBLES; n++) begin
            if (idx == IW'(n)) sum[4*n +: 4] <= add_s;
          end
          carry <= add_co;
          idx   <= idx + IW'(1);
          // The top nibble's carry becomes the word carry-out.
          if (idx == IW'(NIBBLES - 1)) begin
            cout  <= add_co;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: a 4-nibble instance for directed
// cases and a 1-nibble instance swept over every operand/carry combination.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4-nibble instance
  logic        start4 = 1'b0;
  logic        sub4 = 1'b0;
  logic [15:0] op_a4 = '0;
  logic [15:0] op_b4 = '0;
  logic        cin4 = 1'b0;
  logic        busy4, done4, cout4;
  logic [15:0] sum4;
  logic [3:0]  add_a4, add_b4, add_s4;
  logic        add_ci4, add_co4;

  // 1-nibble instance
  logic        start1 = 1'b0;
  logic        sub1 = 1'b0;
  logic [3:0]  op_a1 = '0;
  logic [3:0]  op_b1 = '0;
  logic        cin1 = 1'b0;
  logic        busy1, done1, cout1;
  logic [3:0]  sum1;
  logic [3:0]  add_a1, add_b1, add_s1;
  logic        add_ci1, add_co1;

  // Stand-ins for the external combinational 4-bit ripple adder
  assign {add_co4, add_s4} = {1'b0, add_a4} + {1'b0, add_b4} + {4'b0, add_ci4};
  assign {add_co1, add_s1} = {1'b0, add_a1} + {1'b0, add_b1} + {4'b0, add_ci1};

  nibble_serial_adder #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4),
`ifdef ADDSUB_EN
    .sub(sub4),
`endif
    .op_a(op_a4), .op_b(op_b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4),
    .add_a(add_a4), .add_b(add_b4), .add_ci(add_ci4),
    .add_s(add_s4), .add_co(add_co4)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
`ifdef ADDSUB_EN
    .sub(sub1),
`endif
    .op_a(op_a1), .op_b(op_b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
    .add_a(add_a1), .add_b(add_b1), .add_ci(add_ci1),
    .add_s(add_s1), .add_co(add_co1)
  );

  int errors = 0;
  int checks = 0;
  logic [16:0] q4[$];
  logic [4:0]  q1[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitors pop the scoreboard whenever a done pulse appears
  always @(negedge clk) begin
    if (!rst && done4) begin
      checkOutput("pending_ops4", 32'(q4.size() > 0), 32'd1);
      if (q4.size() > 0) begin
        logic [16:0] e4;
        e4 = q4.pop_front();
        checkOutput("sum4", 32'(sum4), 32'(e4[15:0]));
        checkOutput("cout4", 32'(cout4), 32'(e4[16]));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done1) begin
      checkOutput("pending_ops1", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) begin
        logic [4:0] e1;
        e1 = q1.pop_front();
        checkOutput("sum1", 32'(sum1), 32'(e1[3:0]));
        checkOutput("cout1", 32'(cout1), 32'(e1[4]));
      end
    end
  end

  task automatic waitIdle();
    int n;
    n = 0;
    while ((busy4 || done4) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_timeout", 32'(busy4 || done4), 32'd0);
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic c,
                               input logic s, input logic [15:0] exp_sum, input logic exp_cout);
    int n;
    waitIdle();
    @(negedge clk);
    start4 = 1'b1; op_a4 = a; op_b4 = b; cin4 = c; sub4 = s;
    q4.push_back({exp_cout, exp_sum});
    @(negedge clk);
    start4 = 1'b0; op_a4 = ~a; op_b4 = ~b; cin4 = ~c;
    n = 0;
    while (busy4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("busy_cycles", 32'(n), 32'd4);
    checkOutput("done_after_busy", 32'(done4), 32'd1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("sum_hold", 32'(sum4), 32'(exp_sum));
    checkOutput("cout_hold", 32'(cout4), 32'(exp_cout));
  endtask

  initial begin
    #(10 * 20000);
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] ta[8] = '{16'h0F0F, 16'hDEAD, 16'hBEEF, 16'h1357, 16'h2468, 16'hFFFF, 16'h8000, 16'h7777};
    logic [15:0] tb[8] = '{16'h00F1, 16'h1111, 16'h2222, 16'h3333, 16'hFFFF, 16'hFFFF, 16'h8001, 16'h0001};
    logic        tc[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    int rises[$];
    int dn;
    logic prev_busy;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(busy4), 32'd0);
    checkOutput("rst_done", 32'(done4), 32'd0);
    checkOutput("rst_sum", 32'(sum4), 32'd0);
    checkOutput("rst_cout", 32'(cout4), 32'd0);
    checkOutput("rst_adder_drive", 32'({add_a4, add_b4, add_ci4}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
    applyStimulus(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
    applyStimulus(16'h9999, 16'h9999, 1'b0, 1'b0, 16'h3332, 1'b1);
    applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
`ifdef ADDSUB_EN
    applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    applyStimulus(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
    sub4 = 1'b0;
`endif

    // start held high with operands changing every cycle
    waitIdle();
    q4.push_back({1'b0, 16'h1000});
    q4.push_back({1'b1, 16'h0002});
    dn = 0;
    prev_busy = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k > 0) begin
        if (busy4 && !prev_busy) rises.push_back(k - 1);
        if (done4) dn++;
      end
      prev_busy = busy4;
      if (k < 8) begin
        start4 = 1'b1; op_a4 = ta[k]; op_b4 = tb[k]; cin4 = tc[k];
      end else begin
        start4 = 1'b0;
      end
    end
    checkOutput("accept_count", 32'(rises.size()), 32'd2);
    if (rises.size() == 2) checkOutput("accept_gap", 32'(rises[1] - rises[0]), 32'd6);
    checkOutput("held_done_pulses", 32'(dn), 32'd2);

    // reset in the middle of a run discards the operation
    waitIdle();
    @(negedge clk);
    start4 = 1'b1; op_a4 = 16'hAAAA; op_b4 = 16'h5555; cin4 = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy", 32'(busy4), 32'd0);
    checkOutput("midrst_done", 32'(done4), 32'd0);
    checkOutput("midrst_sum", 32'(sum4), 32'd0);
    checkOutput("midrst_cout", 32'(cout4), 32'd0);
    checkOutput("midrst_adder_drive", 32'({add_a4, add_b4, add_ci4}), 32'd0);
    rst = 1'b0;
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4 || busy4) dn++;
    end
    checkOutput("midrst_no_done", 32'(dn), 32'd0);

    // exhaustive sweep on the single-nibble instance
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          start1 = 1'b1; op_a1 = 4'(a); op_b1 = 4'(b); cin1 = 1'(c);
          q1.push_back(5'(a + b + c));
          @(negedge clk);
          start1 = 1'b0;
          @(negedge clk);
          @(negedge clk);
        end
      end
    end

    repeat (6) @(negedge clk);
    checkOutput("q4_drained", 32'(q4.size()), 32'd0);
    checkOutput("q1_drained", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
